// File: rtl/mx6_seq.sv
// mx6_seq: round-robin 6-source mux sequencer; registers muxq once sel has settled for SETTLE cycles.
// Latency: capture SETTLE edges after the grant edge; sel, dout and dout_valid stay frozen while dout_valid && !dout_ready.
module mx6_seq #(
    parameter int DW     = 16,
    parameter int SETTLE = 1
) (
    input  logic          sys_clk,
    input  logic          resetl,
    input  logic [5:0]    req,
    output logic [5:0]    ack,
    output logic [2:0]    sel,
    input  logic [DW-1:0] muxq,
    output logic [DW-1:0] dout,
    output logic          dout_valid,
    input  logic          dout_ready,
    output logic          busy
);

    if (SETTLE < 1 || SETTLE > 15) begin : g_bad_settle
        $error("mx6_seq: SETTLE must be within 1..15");
    end

    typedef enum logic [1:0] {ST_IDLE, ST_SETTLE, ST_HOLD} state_t;

    localparam logic [3:0] CNT_INIT = 4'(SETTLE - 1);

    state_t        r_state, w_state_nx;
    logic [2:0]    r_sel, w_sel_nx;
    logic [2:0]    r_last, w_last_nx;
    logic [3:0]    r_cnt, w_cnt_nx;
    logic [5:0]    r_ack, w_ack_nx;
    logic [DW-1:0] r_dout, w_dout_nx;
    logic          r_valid, w_valid_nx;
    logic          r_busy;
    logic [2:0]    w_grant;
    logic          w_grant_vld;

    function automatic logic [2:0] f_wrap(input logic [2:0] base, input int k);
        logic [3:0] s;
        s = {1'b0, base} + 4'(k);
        return (s >= 4'd6) ? 3'(s - 4'd6) : s[2:0];
    endfunction

    // Scan from last+6 down to last+1 so the closest source after last wins.
    always_comb begin
        w_grant     = r_last;
        w_grant_vld = 1'b0;
        for (int k = 6; k >= 1; k--) begin
            if (req[f_wrap(r_last, k)]) begin
                w_grant     = f_wrap(r_last, k);
                w_grant_vld = 1'b1;
            end
        end
    end

    always_comb begin
        w_state_nx = r_state;
        w_sel_nx   = r_sel;
        w_cnt_nx   = r_cnt;
        w_last_nx  = r_last;
        w_ack_nx   = '0;
        w_dout_nx  = r_dout;
        w_valid_nx = r_valid;
        case (r_state)
            ST_IDLE: begin
                if (w_grant_vld) begin
                    w_sel_nx   = w_grant;
                    w_cnt_nx   = CNT_INIT;
                    w_state_nx = ST_SETTLE;
                end
            end
            ST_SETTLE: begin
                // A withdrawn request abandons the slot without moving the round-robin pointer.
                if (!req[r_sel]) begin
                    w_state_nx = ST_IDLE;
                end else if (r_cnt != 4'd0) begin
                    w_cnt_nx = r_cnt - 4'd1;
                end else begin
                    w_dout_nx  = muxq;
                    w_valid_nx = 1'b1;
                    w_ack_nx   = 6'(1) << r_sel;
                    w_last_nx  = r_sel;
                    w_state_nx = ST_HOLD;
                end
            end
            ST_HOLD: begin
                if (r_valid && dout_ready) begin
                    w_valid_nx = 1'b0;
                    w_state_nx = ST_IDLE;
                end
            end
            default: w_state_nx = ST_IDLE;
        endcase
    end

    always_ff @(posedge sys_clk or negedge resetl) begin
        if (!resetl) begin
            r_state <= ST_IDLE;
            r_sel   <= 3'd0;
            r_last  <= 3'd5;
            r_cnt   <= 4'd0;
            r_ack   <= '0;
            r_dout  <= '0;
            r_valid <= 1'b0;
            r_busy  <= 1'b0;
        end else begin
            r_state <= w_state_nx;
            r_sel   <= w_sel_nx;
            r_last  <= w_last_nx;
            r_cnt   <= w_cnt_nx;
            r_ack   <= w_ack_nx;
            r_dout  <= w_dout_nx;
            r_valid <= w_valid_nx;
            r_busy  <= (w_state_nx != ST_IDLE);
        end
    end

    assign ack        = r_ack;
    assign sel        = r_sel;
    assign dout       = r_dout;
    assign dout_valid = r_valid;
    assign busy       = r_busy;

endmodule

// File: tb/tb_mx6_seq.sv
// Bench for mx6_seq: two instances (SETTLE=1 and SETTLE=4) share stimulus and are checked
// every cycle against a transaction-level reference model, plus directed expectations.
module tb_mx6_seq;
    localparam int DW = 16;

    logic          sys_clk = 1'b0;
    logic          resetl  = 1'b1;
    logic [5:0]    req     = '0;
    logic [DW-1:0] muxq    = '0;
    logic          dout_ready = 1'b1;

    logic [5:0]    ack0, ack1;
    logic [2:0]    sel0, sel1;
    logic [DW-1:0] dout0, dout1;
    logic          vld0, vld1, busy0, busy1;

    int n_chk  = 0;
    int n_fail = 0;

    always #5 sys_clk = ~sys_clk;

    mx6_seq #(.DW(DW), .SETTLE(1)) u_dut0 (
        .sys_clk(sys_clk), .resetl(resetl), .req(req), .ack(ack0), .sel(sel0),
        .muxq(muxq), .dout(dout0), .dout_valid(vld0), .dout_ready(dout_ready), .busy(busy0)
    );

    mx6_seq #(.DW(DW), .SETTLE(4)) u_dut1 (
        .sys_clk(sys_clk), .resetl(resetl), .req(req), .ack(ack1), .sel(sel1),
        .muxq(muxq), .dout(dout1), .dout_valid(vld1), .dout_ready(dout_ready), .busy(busy1)
    );

    // Reference model: phase 0 = waiting for a request, 1 = sel settling, 2 = word on offer.
    int            m_phase[2];
    int            m_left[2];
    int            m_sel[2];
    int            m_last[2];
    logic [5:0]    m_ack[2];
    logic [DW-1:0] m_dout[2];
    logic          m_vld[2];

    function automatic int settle_of(input int d);
        return (d == 0) ? 1 : 4;
    endfunction

    always @(posedge sys_clk or negedge resetl) begin
        if (!resetl) begin
            for (int d = 0; d < 2; d++) begin
                m_phase[d] = 0; m_left[d] = 0; m_sel[d] = 0; m_last[d] = 5;
                m_ack[d] = '0;  m_dout[d] = '0; m_vld[d] = 1'b0;
            end
        end else begin
            for (int d = 0; d < 2; d++) begin
                int g;
                m_ack[d] = '0;
                case (m_phase[d])
                    0: begin
                        g = -1;
                        for (int k = 1; k <= 6; k++)
                            if (g < 0 && req[(m_last[d] + k) % 6]) g = (m_last[d] + k) % 6;
                        if (g >= 0) begin
                            m_sel[d] = g; m_left[d] = settle_of(d); m_phase[d] = 1;
                        end
                    end
                    1: begin
                        if (!req[m_sel[d]]) m_phase[d] = 0;
                        else begin
                            m_left[d] = m_left[d] - 1;
                            if (m_left[d] == 0) begin
                                m_dout[d] = muxq; m_vld[d] = 1'b1;
                                m_ack[d] = 6'(1) << m_sel[d];
                                m_last[d] = m_sel[d]; m_phase[d] = 2;
                            end
                        end
                    end
                    default: begin
                        if (dout_ready) begin m_vld[d] = 1'b0; m_phase[d] = 0; end
                    end
                endcase
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic check_all();
        chk("sel0",  32'(sel0),  32'(m_sel[0]));
        chk("ack0",  32'(ack0),  32'(m_ack[0]));
        chk("dout0", 32'(dout0), 32'(m_dout[0]));
        chk("vld0",  32'(vld0),  32'(m_vld[0]));
        chk("busy0", 32'(busy0), 32'(m_phase[0] != 0));
        chk("sel1",  32'(sel1),  32'(m_sel[1]));
        chk("ack1",  32'(ack1),  32'(m_ack[1]));
        chk("dout1", 32'(dout1), 32'(m_dout[1]));
        chk("vld1",  32'(vld1),  32'(m_vld[1]));
        chk("busy1", 32'(busy1), 32'(m_phase[1] != 0));
        chk("sel_range", 32'((sel0 <= 3'd5) && (sel1 <= 3'd5)), 32'd1);
    endtask

    task automatic step();
        @(posedge sys_clk);
        #2;
        check_all();
    endtask

    // Asserted 2 time units after an edge; outputs must clear before the next edge.
    task automatic pulse_reset();
        resetl = 1'b0;
        #1;
        check_all();
        chk("rst_outs", {vld0, vld1, busy0, busy1, ack0, ack1, sel0, sel1}, 32'd0);
        @(posedge sys_clk);
        #2;
        resetl = 1'b1;
    endtask

    initial begin
        logic [5:0] exp_ack;
        int         nxt;
        bit         seen;

        #2;
        pulse_reset();

        // Single request, SETTLE=1 timing.
        req = 6'b000001; muxq = 16'hA5A5; dout_ready = 1'b1;
        step();
        chk("t1_sel", 32'(sel0), 32'd0);
        chk("t1_busy", 32'(busy0), 32'd1);
        chk("t1_vld_early", 32'(vld0), 32'd0);
        step();
        chk("t1_dout", 32'(dout0), 32'hA5A5);
        chk("t1_vld", 32'(vld0), 32'd1);
        chk("t1_ack", 32'(ack0), 32'h01);
        req = 6'b000000;
        step();
        chk("t1_vld_drop", 32'(vld0), 32'd0);
        chk("t1_ack_pulse", 32'(ack0), 32'd0);

        // All sources requesting: strict rotation starting after source 0.
        req = 6'b111111; nxt = 1;
        for (int c = 0; c < 36; c++) begin
            muxq = 16'($urandom());
            step();
            if (ack0 != 0) begin
                chk("t2_rr", 32'(ack0), 32'(6'(1) << nxt));
                nxt = (nxt + 1) % 6;
            end
        end
        chk("t2_count", 32'(nxt), 32'd1);

        // Two sources, wrap 5->0 and fairness.
        pulse_reset();
        req = 6'b100001; exp_ack = 6'b000001;
        for (int c = 0; c < 12; c++) begin
            muxq = 16'($urandom());
            step();
            if (ack0 != 0) begin
                chk("t3_rr", 32'(ack0), 32'(exp_ack));
                exp_ack = (exp_ack == 6'b000001) ? 6'b100000 : 6'b000001;
            end
        end

        // Withdrawn request mid-settle on the SETTLE=4 instance.
        pulse_reset();
        req = 6'b001000;
        step(); step(); step();
        req = 6'b000000;
        step();
        chk("t4_busy1", 32'(busy1), 32'd0);
        chk("t4_ack1", 32'(ack1), 32'd0);
        chk("t4_vld1", 32'(vld1), 32'd0);
        chk("t4_dout1", 32'(dout1), 32'd0);
        req = 6'b111111; seen = 1'b0;
        for (int c = 0; c < 20 && !seen; c++) begin
            step();
            if (ack1 != 0) begin
                chk("t4_next_grant", 32'(ack1), 32'h01);
                seen = 1'b1;
            end
        end
        chk("t4_timeout", 32'(seen), 32'd1);

        // Downstream stall while holding a word; muxq glitches must not leak.
        pulse_reset();
        req = 6'b000100; muxq = 16'h1234; dout_ready = 1'b0;
        step(); step();
        chk("t5_ack", 32'(ack0), 32'h04);
        req = 6'b000000;
        for (int c = 0; c < 10; c++) begin
            muxq = 16'($urandom());
            step();
            chk("t5_dout", 32'(dout0), 32'h1234);
            chk("t5_sel", 32'(sel0), 32'd2);
            chk("t5_vld", 32'(vld0), 32'd1);
        end
        dout_ready = 1'b1;
        step();
        chk("t5_vld_drop", 32'(vld0), 32'd0);
        req = 6'b010000;
        step();
        chk("t5_next_sel", 32'(sel0), 32'd4);

        // Reset during SETTLE and during HOLD.
        pulse_reset();
        req = 6'b111111;
        step();
        pulse_reset();
        req = 6'b101100;
        step();
        chk("t6_sel0", 32'(sel0), 32'd2);
        chk("t6_sel1", 32'(sel1), 32'd2);
        step();
        chk("t6_hold_vld", 32'(vld0), 32'd1);
        pulse_reset();
        chk("t6_ack_after", 32'(ack0), 32'd0);

        // Randomised traffic with backpressure, withdrawals and occasional resets.
        for (int c = 0; c < 800; c++) begin
            muxq       = 16'($urandom());
            dout_ready = ($urandom_range(0, 9) < 7);
            for (int i = 0; i < 6; i++) begin
                if ($urandom_range(0, 7) == 0) req[i] = ~req[i];
                if (ack0[i] && $urandom_range(0, 1) == 1) req[i] = 1'b0;
            end
            if ($urandom_range(0, 149) == 0) pulse_reset();
            else step();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
